// File: rtl/m3_key_conditioner_if.sv
// Key bundle between the board pins and the key conditioner: the seven raw
// push-button/switch inputs and the conditioned pulses/levels.
interface m3_key_conditioner_if;
    logic m3startI;
    logic m3forceStopI;
    logic m3invRotateI;
    logic m3freqINCi;
    logic m3freqDECi;
    logic m3powerINCi;
    logic m3powerDECi;

    logic m3startPo;
    logic m3forceStopO;
    logic m3invRotateO;
    logic m3freqINCpo;
    logic m3freqDECpo;
    logic m3powerINCpo;
    logic m3powerDECpo;

    // Board side: drives the raw keys and observes the conditioned outputs.
    modport master (
        output m3startI, m3forceStopI, m3invRotateI,
        output m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
        input  m3startPo, m3forceStopO, m3invRotateO,
        input  m3freqINCpo, m3freqDECpo, m3powerINCpo, m3powerDECpo
    );

    // Conditioner side: samples the raw keys and produces the conditioned outputs.
    modport slave (
        input  m3startI, m3forceStopI, m3invRotateI,
        input  m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
        output m3startPo, m3forceStopO, m3invRotateO,
        output m3freqINCpo, m3freqDECpo, m3powerINCpo, m3powerDECpo
    );
endinterface

// File: rtl/m3_key_conditioner.sv
// m3_key_conditioner: synchronises and debounces the seven motor-control keys,
// turns start and the INC/DEC keys into single-cycle command pulses (INC/DEC
// auto-repeat while held, with INC/DEC pair conflicts blocked) and presents
// forceStop/invRotate as clean levels.
module m3_key_conditioner #(
    parameter int TICK_DIV     = 1000,
    parameter int DEB_TICKS    = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                clkI,
    input  logic                nRstI,
    m3_key_conditioner_if.slave keys
);
    localparam int NKEY    = 7;
    localparam int NREP    = 4;
    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int DEB_W   = $clog2(DEB_TICKS + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // Key positions inside the packed key vectors.
    localparam int K_START = 0;
    localparam int K_FSTOP = 1;
    localparam int K_INV   = 2;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_RATE,
        REP_BLOCK
    } repState_t;

    logic [NKEY-1:0]  rawVec;
    logic [NKEY-1:0]  sync1_q;
    logic [NKEY-1:0]  sync2_q;
    logic [NKEY-1:0]  stable_q;
    logic [NKEY-1:0]  stable_d;
    logic [DEB_W-1:0] debCnt_q [NKEY];
    logic [DEB_W-1:0] debCnt_d [NKEY];

    logic [DIV_W-1:0] divCnt_q;
    logic [DIV_W-1:0] divCnt_d;
    logic             tick;

    logic             startPrev_q;
    logic             startPo_q;
    logic             forceStop_q;
    logic             invRotate_q;

    repState_t        repState_q [NREP];
    repState_t        repState_d [NREP];
    logic [REP_W-1:0] repCnt_q   [NREP];
    logic [REP_W-1:0] repCnt_d   [NREP];
    logic [NREP-1:0]  pulse_q;
    logic [NREP-1:0]  pulse_d;
    logic [NREP-1:0]  repOwn;
    logic [NREP-1:0]  repPartner;

    assign rawVec = {keys.m3powerDECi, keys.m3powerINCi, keys.m3freqDECi, keys.m3freqINCi,
                     keys.m3invRotateI, keys.m3forceStopI, keys.m3startI};

    // Repeat channels 0..3 are freqINC, freqDEC, powerINC, powerDEC; each one's
    // partner is the opposite key of the same pair.
    assign repOwn     = stable_q[6:3];
    assign repPartner = {stable_q[5], stable_q[6], stable_q[3], stable_q[4]};

    // Two-flop synchroniser; active-low boards are normalised to active-high here.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawVec ^ {NKEY{ACTIVE_LOW}};
            sync2_q <= sync1_q;
        end
    end

    assign tick     = (divCnt_q == DIV_W'(TICK_DIV - 1));
    assign divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);

    // Free-running tick divider shared by debounce and auto-repeat timing.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_d;
        end
    end

    // A key's stable state flips only after DEB_TICKS consecutive disagreeing ticks.
    always_comb begin
        stable_d = stable_q;
        for (int k = 0; k < NKEY; k++) begin
            debCnt_d[k] = debCnt_q[k];
            if (tick) begin
                if (sync2_q[k] != stable_q[k]) begin
                    if (debCnt_q[k] == DEB_W'(DEB_TICKS - 1)) begin
                        stable_d[k] = sync2_q[k];
                        debCnt_d[k] = '0;
                    end else begin
                        debCnt_d[k] = debCnt_q[k] + DEB_W'(1);
                    end
                end else begin
                    debCnt_d[k] = '0;
                end
            end
        end
    end

    // Debounce state registers; a reset mid-press leaves the key released.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            stable_q <= '0;
            for (int k = 0; k < NKEY; k++) begin
                debCnt_q[k] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int k = 0; k < NKEY; k++) begin
                debCnt_q[k] <= debCnt_d[k];
            end
        end
    end

    // Start edge pulse (suppressed while forceStop is stable high) and the two level outputs.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            startPrev_q <= 1'b0;
            startPo_q   <= 1'b0;
            forceStop_q <= 1'b0;
            invRotate_q <= 1'b0;
        end else begin
            startPrev_q <= stable_q[K_START];
            startPo_q   <= stable_q[K_START] & ~startPrev_q & ~stable_q[K_FSTOP];
            forceStop_q <= stable_q[K_FSTOP];
            invRotate_q <= stable_q[K_INV];
        end
    end

    // Per-key repeat FSM: first pulse on press, then delayed and periodic repeats;
    // the limit compare runs on the registered count so each repeat lands a whole
    // number of tick periods after the previous pulse.
    always_comb begin
        for (int j = 0; j < NREP; j++) begin
            repState_d[j] = repState_q[j];
            repCnt_d[j]   = repCnt_q[j];
            pulse_d[j]    = 1'b0;
            case (repState_q[j])
                REP_IDLE: begin
                    if (repOwn[j] && repPartner[j]) begin
                        repState_d[j] = REP_BLOCK;
                    end else if (repOwn[j]) begin
                        pulse_d[j]    = 1'b1;
                        repState_d[j] = REP_DELAY;
                        repCnt_d[j]   = '0;
                    end
                end
                REP_DELAY: begin
                    if (!repOwn[j]) begin
                        repState_d[j] = REP_IDLE;
                        repCnt_d[j]   = '0;
                    end else if (repPartner[j]) begin
                        repState_d[j] = REP_BLOCK;
                        repCnt_d[j]   = '0;
                    end else if (repCnt_q[j] == REP_W'(REPEAT_DELAY)) begin
                        pulse_d[j]    = 1'b1;
                        repState_d[j] = REP_RATE;
                        repCnt_d[j]   = '0;
                    end else if (tick) begin
                        repCnt_d[j] = repCnt_q[j] + REP_W'(1);
                    end
                end
                REP_RATE: begin
                    if (!repOwn[j]) begin
                        repState_d[j] = REP_IDLE;
                        repCnt_d[j]   = '0;
                    end else if (repPartner[j]) begin
                        repState_d[j] = REP_BLOCK;
                        repCnt_d[j]   = '0;
                    end else if (repCnt_q[j] == REP_W'(REPEAT_RATE)) begin
                        pulse_d[j]  = 1'b1;
                        repCnt_d[j] = '0;
                    end else if (tick) begin
                        repCnt_d[j] = repCnt_q[j] + REP_W'(1);
                    end
                end
                REP_BLOCK: begin
                    if (!repOwn[j]) begin
                        repState_d[j] = REP_IDLE;
                        repCnt_d[j]   = '0;
                    end else if (!repPartner[j]) begin
                        repState_d[j] = REP_DELAY;
                        repCnt_d[j]   = '0;
                    end
                end
                default: begin
                    repState_d[j] = REP_IDLE;
                    repCnt_d[j]   = '0;
                end
            endcase
        end
    end

    // Repeat FSM state, counters and registered pulse strobes.
    always_ff @(posedge clkI) begin
        if (!nRstI) begin
            pulse_q <= '0;
            for (int j = 0; j < NREP; j++) begin
                repState_q[j] <= REP_IDLE;
                repCnt_q[j]   <= '0;
            end
        end else begin
            pulse_q <= pulse_d;
            for (int j = 0; j < NREP; j++) begin
                repState_q[j] <= repState_d[j];
                repCnt_q[j]   <= repCnt_d[j];
            end
        end
    end

    assign keys.m3startPo    = startPo_q;
    assign keys.m3forceStopO = forceStop_q;
    assign keys.m3invRotateO = invRotate_q;
    assign keys.m3freqINCpo  = pulse_q[0];
    assign keys.m3freqDECpo  = pulse_q[1];
    assign keys.m3powerINCpo = pulse_q[2];
    assign keys.m3powerDECpo = pulse_q[3];
endmodule
